// File: rtl/alu_logic_arbiter.sv
// Two-requester round-robin arbiter in front of a 16-bit logical ALU with a
// one-entry registered, tagged response and a saturating illegal-opcode count.
module alu_logic_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [ERRW-1:0]  err_count
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b1000,
    OP_OR   = 4'b1001,
    OP_NAND = 4'b1010,
    OP_NOR  = 4'b1011,
    OP_NOT  = 4'b1100,
    OP_XOR  = 4'b1101
  } op_e;

  logic             last;
  logic             grant;
  logic             can_accept;
  logic             accept;
  logic             illegal;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] result;

  // Round-robin grant: a lone requester wins, on contention the one not served last wins
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Handshake: output register is free when empty or being drained this cycle
  always_comb begin
    can_accept = !rsp_valid || rsp_ready;
    req0_ready = (grant == 1'b0) && req0_valid && can_accept && !rst;
    req1_ready = (grant == 1'b1) && req1_valid && can_accept && !rst;
    accept     = req0_ready || req1_ready;
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_op = grant ? req1_opcode : req0_opcode;
    sel_a  = grant ? req1_a      : req0_a;
    sel_b  = grant ? req1_b      : req0_b;
  end

  // Logical operation; unknown opcodes yield zero and raise the illegal flag
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (sel_op)
      OP_AND:  result = sel_a & sel_b;
      OP_OR:   result = sel_a | sel_b;
      OP_NAND: result = ~(sel_a & sel_b);
      OP_NOR:  result = ~(sel_a | sel_b);
      OP_NOT:  result = ~sel_a;
      OP_XOR:  result = sel_a ^ sel_b;
      default: illegal = 1'b1;
    endcase
  end

  // Response register, round-robin history and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      err_count <= '0;
      last      <= 1'b1;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= result;
      rsp_err   <= illegal;
      rsp_id    <= grant;
      last      <= grant;
      if (illegal && (err_count != '1)) begin
        err_count <= err_count + ERRW'(1);
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
